// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller and its MDU sequencer.
package hazard_ctrl_pkg;
  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;
  localparam int unsigned TW           = 2;
  localparam int unsigned RW           = 5;
  localparam int unsigned SCW          = 16;
  localparam logic [TW-1:0] TUSE_NONE  = 2'd3;
endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// MDU busy sequencer: down-counter, one-cycle done pulse and sticky overlap error.
module mdu_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int unsigned CW = $clog2(DIV_CYC + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // A start is only accepted from idle; the last busy cycle still counts as busy.
  always_comb begin
    cnt_nxt = cnt;
    if (cnt != '0) begin
      cnt_nxt = cnt - CW'(1);
    end else if (start) begin
      cnt_nxt = div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      done <= (cnt == CW'(1));
      if (start && (cnt != '0)) err <= 1'b1;
    end
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// D-stage hazard detection: RAW stalls against E/M, MDU interlock and stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [RW-1:0]  rs_D,
  input  logic [RW-1:0]  rt_D,
  input  logic [TW-1:0]  tuse_rs_D,
  input  logic [TW-1:0]  tuse_rt_D,
  input  logic           md_D,
  input  logic [RW-1:0]  wa_E,
  input  logic [RW-1:0]  wa_M,
  input  logic [TW-1:0]  tnew_E,
  input  logic [TW-1:0]  tnew_M,
  input  logic           RWE_E,
  input  logic           RWE_M,
  input  logic           start_E,
  input  logic           div_E,
  output logic           stall,
  output logic           clr_DE,
  output logic           mdu_busy,
  output logic           mdu_done,
  output logic           mdu_err,
  output logic [SCW-1:0] stall_cnt
);
  logic hz_rs;
  logic hz_rt;
  logic hz_md;

  mdu_seq #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_mdu_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_E),
    .div   (div_E),
    .busy  (mdu_busy),
    .done  (mdu_done),
    .err   (mdu_err)
  );

  // A producer blocks D when its result arrives later than D needs it; unused operands never block.
  always_comb begin
    hz_rs = (rs_D != '0) && (tuse_rs_D != TUSE_NONE) &&
            ((RWE_E && (wa_E == rs_D) && (tuse_rs_D < tnew_E)) ||
             (RWE_M && (wa_M == rs_D) && (tuse_rs_D < tnew_M)));
    hz_rt = (rt_D != '0) && (tuse_rt_D != TUSE_NONE) &&
            ((RWE_E && (wa_E == rt_D) && (tuse_rt_D < tnew_E)) ||
             (RWE_M && (wa_M == rt_D) && (tuse_rt_D < tnew_M)));
    hz_md = md_D && (start_E || mdu_busy);
  end

  assign stall  = hz_rs || hz_rt || hz_md;
  assign clr_DE = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + SCW'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed checks of hazard_ctrl against a cycle-indexed behavioural model.
module tb_hazard_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_D, rt_D, wa_E, wa_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_D, RWE_E, RWE_M, start_E, div_E;
  logic        stall, clr_DE, mdu_busy, mdu_done, mdu_err;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Model state: operations are tracked by absolute cycle numbers, not counters.
  int cyc = 0;
  int busy_end = -1;
  int done_at = -1;
  bit m_err = 1'b0;
  int m_scnt = 0;

  hazard_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk(clk), .rst_n(rst_n), .rs_D(rs_D), .rt_D(rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .md_D(md_D),
    .wa_E(wa_E), .wa_M(wa_M), .tnew_E(tnew_E), .tnew_M(tnew_M),
    .RWE_E(RWE_E), .RWE_M(RWE_M), .start_E(start_E), .div_E(div_E),
    .stall(stall), .clr_DE(clr_DE), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .mdu_err(mdu_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Operand must wait if some pending writer to it delivers later than the operand is needed.
  function automatic bit src_hz(input logic [4:0] r, input logic [1:0] tu);
    bit h = 1'b0;
    if (r != 5'd0) begin
      if (RWE_E && wa_E == r && int'(tu) < int'(tnew_E)) h = 1'b1;
      if (RWE_M && wa_M == r && int'(tu) < int'(tnew_M)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic bit m_busy();
    return rst_n && (cyc <= busy_end);
  endfunction

  function automatic bit m_stall();
    return src_hz(rs_D, tuse_rs_D) || src_hz(rt_D, tuse_rt_D) ||
           (md_D && (start_E || m_busy()));
  endfunction

  // Compare every output against the model, then advance one clock.
  task automatic step();
    bit st;
    #2;
    if (!rst_n) begin
      busy_end = -1; done_at = -1; m_err = 1'b0; m_scnt = 0;
    end
    st = m_stall();
    chk("stall", 32'(stall), 32'(st));
    chk("clr_DE", 32'(clr_DE), 32'(st));
    chk("mdu_busy", 32'(mdu_busy), 32'(m_busy()));
    chk("mdu_done", 32'(mdu_done), 32'(rst_n && cyc == done_at));
    chk("mdu_err", 32'(mdu_err), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    @(posedge clk);
    if (rst_n) begin
      if (st && m_scnt < 65535) m_scnt++;
      if (start_E) begin
        if (m_busy()) m_err = 1'b1;
        else begin
          busy_end = cyc + (div_E ? DC : MC);
          done_at  = busy_end + 1;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    rs_D = 0; rt_D = 0; wa_E = 0; wa_M = 0;
    tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = 0; tnew_M = 0;
    md_D = 0; RWE_E = 0; RWE_M = 0; start_E = 0; div_E = 0;
  endtask

  initial begin
    int nb;
    bit prev_start;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(mdu_busy), 32'd0);
    chk("reset_scnt", 32'(stall_cnt), 32'd0);
    chk("reset_err", 32'(mdu_err), 32'd0);
    // Reset gates MDU interlock to start_E only.
    md_D = 1; start_E = 1;
    #1 chk("reset_md_stall", 32'(stall), 32'd1);
    step();
    md_D = 0; start_E = 0;
    step();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use hazard and its release.
    wa_E = 8; tnew_E = 2; RWE_E = 1; rs_D = 8; tuse_rs_D = 1;
    #1 chk("loaduse_stall", 32'(stall), 32'd1);
    chk("loaduse_clr", 32'(clr_DE), 32'd1);
    step();
    RWE_E = 0; wa_M = 8; tnew_M = 1; RWE_M = 1;
    #1 chk("release_stall", 32'(stall), 32'd0);
    step();
    RWE_E = 1; RWE_M = 0; rs_D = 0;
    #1 chk("rs0_stall", 32'(stall), 32'd0);
    step();
    idle_inputs();
    wa_E = 8; tnew_E = 3; RWE_E = 1; rs_D = 8; tuse_rs_D = 3;
    #1 chk("tuse3_stall", 32'(stall), 32'd0);
    step();

    // Multiply with md_D interlock.
    idle_inputs();
    md_D = 1; start_E = 1;
    #1 chk("mul_start_stall", 32'(stall), 32'd1);
    step();
    start_E = 0;
    for (int i = 1; i <= MC; i++) begin
      #1 chk("mul_busy", 32'(mdu_busy), 32'd1);
      chk("mul_busy_stall", 32'(stall), 32'd1);
      step();
    end
    #1 chk("mul_done", 32'(mdu_done), 32'd1);
    chk("mul_idle", 32'(mdu_busy), 32'd0);
    chk("mul_idle_stall", 32'(stall), 32'd0);
    step();
    #1 chk("mul_done_once", 32'(mdu_done), 32'd0);
    md_D = 0;
    step();

    // Divide busy length.
    start_E = 1; div_E = 1;
    step();
    start_E = 0; div_E = 0; nb = 0;
    for (int i = 0; i < DC + 3; i++) begin
      if (mdu_busy) nb++;
      step();
    end
    chk("div_busy_len", 32'(nb), 32'(DC));

    // Start while busy, including on the final busy cycle.
    start_E = 1;
    step();
    start_E = 0;
    step(); step();
    start_E = 1;
    step();
    start_E = 0;
    step();
    start_E = 1;
    #1 chk("last_busy", 32'(mdu_busy), 32'd1);
    step();
    start_E = 0;
    #1 chk("err_done_sched", 32'(mdu_done), 32'd1);
    chk("err_busy_after", 32'(mdu_busy), 32'd0);
    chk("err_sticky", 32'(mdu_err), 32'd1);
    step();

    // Reset at busy cycle 4 aborts the operation without a done pulse.
    start_E = 1;
    step();
    start_E = 0;
    step(); step(); step();
    rst_n = 1'b0;
    #1 chk("rst_busy", 32'(mdu_busy), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    chk("rst_err", 32'(mdu_err), 32'd0);
    step();
    rst_n = 1'b1;
    start_E = 1;
    step();
    start_E = 0;
    #1 chk("post_rst_accept", 32'(mdu_busy), 32'd1);
    for (int i = 0; i < MC + 2; i++) step();

    // Randomized traffic with occasional resets.
    prev_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      wa_E = 5'($urandom_range(0, 3)); wa_M = 5'($urandom_range(0, 3));
      tuse_rs_D = 2'($urandom_range(0, 3)); tuse_rt_D = 2'($urandom_range(0, 3));
      tnew_E = 2'($urandom_range(0, 3)); tnew_M = 2'($urandom_range(0, 3));
      RWE_E = 1'($urandom_range(0, 1)); RWE_M = 1'($urandom_range(0, 1));
      md_D = 1'($urandom_range(0, 1)); div_E = 1'($urandom_range(0, 1));
      start_E = !prev_start && ($urandom_range(0, 5) == 0);
      prev_start = start_E;
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;

    // Saturation of the stall counter.
    idle_inputs();
    wa_E = 8; tnew_E = 2; RWE_E = 1; rs_D = 8; tuse_rs_D = 1;
    for (int i = 0; i < 70000; i++) step();
    #1 chk("scnt_sat", 32'(stall_cnt), 32'h0000FFFF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
